// File: rtl/mul8_pkg.sv
// mul8_pkg: shared types and widths for the shared 8x8 multiplier arbiter
package mul8_pkg;
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    localparam int OPW = 8;
    localparam int PW  = 16;
    localparam int IDW = 3;
endpackage

// File: rtl/mul8_rr_pick.sv
// mul8_rr_pick: combinational round-robin picker
//   valid in NREQ request vector, ptr in IDW highest-priority index,
//   grant out NREQ one-hot winner, idx out IDW winner index, any out 1 some request valid
module mul8_rr_pick
    import mul8_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    int j;
    // Scan offsets from farthest to nearest so the requester at ptr is written last and wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (valid[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IDW'(j);
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/multiplier_array_8bit.sv
// multiplier_array_8bit: combinational 8x8 unsigned array multiplier
//   XA in 8 multiplicand, Y in 8 multiplier, P out 16 product
module multiplier_array_8bit (
    input  logic [7:0]  XA,
    input  logic [7:0]  Y,
    output logic [15:0] P
);
    always_comb begin
        P = '0;
        for (int i = 0; i < 8; i++)
            P = P + (Y[i] ? ({8'b0, XA} << i) : 16'b0);
    end
endmodule

// File: rtl/mul8_share_arbiter.sv
// mul8_share_arbiter: round-robin sharing of one 8x8 multiplier among NREQ requesters
//   clk/rst_n clock and async active-low reset
//   req_valid/req_ready/req_a/req_b  per-requester operand handshake (8 bits each)
//   resp_valid/resp_ready/resp_p/resp_id  registered product and owning requester
//   busy  high whenever an operation is in flight or awaiting pickup
module mul8_share_arbiter
    import mul8_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [OPW*NREQ-1:0] req_a,
    input  logic [OPW*NREQ-1:0] req_b,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [PW-1:0]       resp_p,
    output logic [IDW-1:0]      resp_id,
    output logic                busy
);
    localparam int CW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;

    if (SETTLE_CYC < 1 || NREQ < 2 || NREQ > 8) begin : g_param_check
        $error("mul8_share_arbiter: SETTLE_CYC must be >=1 and NREQ in 2..8");
    end

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]  ptr_q, ptr_d, id_q, id_d, rid_q, rid_d;
    logic [OPW-1:0]  a_q, a_d, b_q, b_d;
    logic [PW-1:0]   p_q, p_d, prod;
    logic            rv_q, rv_d;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gidx;
    logic            gany;

    mul8_rr_pick #(.NREQ(NREQ)) u_pick (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    multiplier_array_8bit u_mul (
        .XA (a_q),
        .Y  (b_q),
        .P  (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            id_q    <= '0;
            rid_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            rid_q   <= rid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            rv_q    <= rv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        rid_d   = rid_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        rv_d    = rv_q;
        case (state_q)
            IDLE: if (gany) begin
                a_d     = req_a[int'(gidx)*OPW +: OPW];
                b_d     = req_b[int'(gidx)*OPW +: OPW];
                id_d    = gidx;
                ptr_d   = (int'(gidx) == NREQ - 1) ? '0 : gidx + IDW'(1);
                cnt_d   = CW'(SETTLE_CYC - 1);
                state_d = MUL;
            end
            MUL: if (cnt_q == '0) begin
                p_d     = prod;
                rid_d   = id_q;
                rv_d    = 1'b1;
                state_d = DONE;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            DONE: if (resp_ready) begin
                rv_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE) ? grant : '0;
        busy       = state_q != IDLE;
        resp_valid = rv_q;
        resp_p     = p_q;
        resp_id    = rid_q;
    end
endmodule
